// File: rtl/clock_pkg.sv
// Shared types and constants for the binary clock time-setting logic.
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_H  = 3'd1,
    ST_SET_M  = 3'd2,
    ST_SET_S  = 3'd3,
    ST_COMMIT = 3'd4
  } set_state_t;

  localparam logic [4:0] HOURS_MAX  = 5'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;

  localparam logic [1:0] FLD_H = 2'd0;
  localparam logic [1:0] FLD_M = 2'd1;
  localparam logic [1:0] FLD_S = 2'd2;

  function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max);
    return (val == max) ? 6'd0 : val + 6'd1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced, synchronized button level.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic btn_q, btn_d;
  logic arm_q, arm_d;

  always_comb begin
    btn_d = btn;
    arm_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      btn_q <= btn_d;
      arm_q <= arm_d;
    end
  end

  // arm_q masks the first cycle after reset so a button held through reset is not a press
  assign rise = btn & ~btn_q & arm_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting FSM, edit registers, idle timeout, blink generator and
// display multiplexer for the binary clock.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int DISP_DIV  = 4,
  parameter int BLINK_DIV = 50,
  parameter int TIMEOUT   = 6000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  output logic       run,
  output logic       load,
  output logic [4:0] load_hours,
  output logic [5:0] load_minutes,
  output logic [5:0] load_seconds,
  output logic       editing,
  output logic [1:0] disp_sel,
  output logic [7:0] disp_data
);

  localparam int SW = (DISP_DIV > 1) ? $clog2(DISP_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int IW = $clog2(TIMEOUT);

  logic mode_rise, inc_rise;

  btn_edge u_mode_edge (.clk(clk), .rst(rst), .btn(btn_mode), .rise(mode_rise));
  btn_edge u_inc_edge  (.clk(clk), .rst(rst), .btn(btn_inc),  .rise(inc_rise));

  set_state_t    state_q, state_d;
  logic [4:0]    eh_q, eh_d;
  logic [5:0]    em_q, em_d;
  logic [5:0]    es_q, es_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [4:0]    load_hours_q, load_hours_d;
  logic [5:0]    load_minutes_q, load_minutes_d;
  logic [5:0]    load_seconds_q, load_seconds_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0]    disp_sel_q, disp_sel_d;
  logic [7:0]    disp_data_q, disp_data_d;
  logic [5:0]    hours_inc_s;
  logic [7:0]    field_val_s;
  logic          blank_s;

  assign hours_inc_s = wrap_inc({1'b0, eh_q}, {1'b0, HOURS_MAX});

  always_comb begin
    state_d        = state_q;
    eh_d           = eh_q;
    em_d           = em_q;
    es_d           = es_q;
    idle_d         = idle_q;
    blink_cnt_d    = blink_cnt_q;
    phase_d        = phase_q;
    load_hours_d   = load_hours_q;
    load_minutes_d = load_minutes_q;
    load_seconds_d = load_seconds_q;

    case (state_q)
      ST_RUN: begin
        idle_d      = '0;
        blink_cnt_d = '0;
        phase_d     = 1'b1;
        if (mode_rise) begin
          state_d = ST_SET_H;
          eh_d    = cur_hours;
          em_d    = cur_minutes;
          es_d    = cur_seconds;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_SET_H, ST_SET_M, ST_SET_S: begin
        if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
          blink_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + BW'(1);
          phase_d     = phase_q;
        end
        // Mode beats inc, and any rise beats the timeout on the same cycle
        if (mode_rise) begin
          idle_d      = '0;
          blink_cnt_d = '0;
          phase_d     = 1'b1;
          case (state_q)
            ST_SET_H: state_d = ST_SET_M;
            ST_SET_M: state_d = ST_SET_S;
            default: begin
              state_d        = ST_COMMIT;
              load_hours_d   = eh_q;
              load_minutes_d = em_q;
              load_seconds_d = es_q;
            end
          endcase
        end else if (inc_rise) begin
          idle_d      = '0;
          blink_cnt_d = '0;
          phase_d     = 1'b1;
          case (state_q)
            ST_SET_H: eh_d = hours_inc_s[4:0];
            ST_SET_M: em_d = wrap_inc(em_q, MINSEC_MAX);
            default:  es_d = wrap_inc(es_q, MINSEC_MAX);
          endcase
        end else if (idle_q == IW'(TIMEOUT - 1)) begin
          state_d = ST_RUN;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      ST_COMMIT: begin
        state_d     = ST_RUN;
        idle_d      = '0;
        blink_cnt_d = '0;
        phase_d     = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Display values are built from next-cycle state so sel/data stay a matched pair
  always_comb begin
    if (slot_q == SW'(DISP_DIV - 1)) begin
      slot_d     = '0;
      disp_sel_d = (disp_sel_q == FLD_S) ? FLD_H : disp_sel_q + 2'd1;
    end else begin
      slot_d     = slot_q + SW'(1);
      disp_sel_d = disp_sel_q;
    end

    case (disp_sel_d)
      FLD_H:   field_val_s = (state_d == ST_RUN) ? {3'd0, cur_hours}   : {3'd0, eh_d};
      FLD_M:   field_val_s = (state_d == ST_RUN) ? {2'd0, cur_minutes} : {2'd0, em_d};
      default: field_val_s = (state_d == ST_RUN) ? {2'd0, cur_seconds} : {2'd0, es_d};
    endcase

    case (state_d)
      ST_SET_H: blank_s = (disp_sel_d == FLD_H);
      ST_SET_M: blank_s = (disp_sel_d == FLD_M);
      ST_SET_S: blank_s = (disp_sel_d == FLD_S);
      default:  blank_s = 1'b0;
    endcase

    disp_data_d = (blank_s && !phase_d) ? 8'd0 : field_val_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      eh_q           <= 5'd0;
      em_q           <= 6'd0;
      es_q           <= 6'd0;
      idle_q         <= '0;
      blink_cnt_q    <= '0;
      phase_q        <= 1'b1;
      load_hours_q   <= 5'd0;
      load_minutes_q <= 6'd0;
      load_seconds_q <= 6'd0;
      slot_q         <= '0;
      disp_sel_q     <= 2'd0;
      disp_data_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      eh_q           <= eh_d;
      em_q           <= em_d;
      es_q           <= es_d;
      idle_q         <= idle_d;
      blink_cnt_q    <= blink_cnt_d;
      phase_q        <= phase_d;
      load_hours_q   <= load_hours_d;
      load_minutes_q <= load_minutes_d;
      load_seconds_q <= load_seconds_d;
      slot_q         <= slot_d;
      disp_sel_q     <= disp_sel_d;
      disp_data_q    <= disp_data_d;
    end
  end

  assign run          = (state_q == ST_RUN) & ~rst;
  assign editing      = ((state_q == ST_SET_H) | (state_q == ST_SET_M) | (state_q == ST_SET_S)) & ~rst;
  assign load         = (state_q == ST_COMMIT) & ~rst;
  assign load_hours   = load_hours_q;
  assign load_minutes = load_minutes_q;
  assign load_seconds = load_seconds_q;
  assign disp_sel     = disp_sel_q;
  assign disp_data    = disp_data_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed self-checking bench for time_set_ctrl with default parameters.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [5:0] cur_seconds;
  logic       run;
  logic       load;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;
  logic [5:0] load_seconds;
  logic       editing;
  logic [1:0] disp_sel;
  logic [7:0] disp_data;

  int n_checks = 0;
  int n_pass   = 0;
  int load_cnt = 0;
  int overlap  = 0;

  time_set_ctrl dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .cur_seconds(cur_seconds),
    .run(run), .load(load), .load_hours(load_hours), .load_minutes(load_minutes),
    .load_seconds(load_seconds), .editing(editing), .disp_sel(disp_sel),
    .disp_data(disp_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load === 1'b1) load_cnt++;
    if (run === 1'b1 && editing === 1'b1) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_inc();
    btn_inc = 1'b1;
    @(negedge clk);
    btn_inc = 1'b0;
    @(negedge clk);
  endtask

  task automatic commit_check(input string tag, input int h, input int m, input int s);
    btn_mode = 1'b1;
    @(negedge clk);
    chk({tag, "_load"}, load, 1);
    chk({tag, "_run_low"}, run, 0);
    chk({tag, "_lh"}, load_hours, h);
    chk({tag, "_lm"}, load_minutes, m);
    chk({tag, "_ls"}, load_seconds, s);
    btn_mode = 1'b0;
    @(negedge clk);
    chk({tag, "_load_end"}, load, 0);
    chk({tag, "_run_back"}, run, 1);
    chk({tag, "_lh_hold"}, load_hours, h);
  endtask

  initial begin
    int exp_sel;
    int exp_val;

    rst = 1'b1;
    btn_mode = 1'b1;
    btn_inc = 1'b0;
    cur_hours = 5'd10;
    cur_minutes = 6'd20;
    cur_seconds = 6'd30;

    // Reset with mode held high
    repeat (3) @(negedge clk);
    chk("rst_run", run, 0);
    chk("rst_editing", editing, 0);
    chk("rst_load", load, 0);
    chk("rst_sel", disp_sel, 0);
    chk("rst_data", disp_data, 0);
    chk("rst_lh", load_hours, 0);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_sel = (k / 4) % 3;
      exp_val = (exp_sel == 0) ? 10 : (exp_sel == 1) ? 20 : 30;
      chk("sched_sel", disp_sel, exp_sel);
      chk("sched_data", disp_data, exp_val);
    end
    chk("held_btn_run", run, 1);
    chk("held_btn_editing", editing, 0);
    btn_mode = 1'b0;
    @(negedge clk);

    // Full edit with wraps
    cur_hours = 5'd23;
    cur_minutes = 6'd59;
    cur_seconds = 6'd58;
    press_mode();
    chk("seth_editing", editing, 1);
    chk("seth_run", run, 0);
    press_inc();
    press_mode();
    press_inc();
    press_mode();
    press_inc();
    commit_check("wrap", 0, 0, 59);
    #1;
    chk("wrap_load_count", load_cnt, 1);
    chk("wrap_no_overlap", overlap, 0);

    // Simultaneous mode and inc in SET_H
    press_mode();
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    @(negedge clk);
    chk("simul_editing", editing, 1);
    press_mode();
    commit_check("simul", 23, 59, 58);

    // Idle timeout from SET_M
    cur_hours = 5'd5;
    cur_minutes = 6'd6;
    cur_seconds = 6'd7;
    press_mode();
    press_mode();
    repeat (5998) @(negedge clk);
    chk("timeout_pre_editing", editing, 1);
    @(negedge clk);
    chk("timeout_run", run, 1);
    chk("timeout_editing", editing, 0);
    chk("timeout_lh", load_hours, 23);
    chk("timeout_lm", load_minutes, 59);
    chk("timeout_ls", load_seconds, 58);
    #1;
    chk("timeout_load_count", load_cnt, 2);
    @(negedge clk);

    // Blink of the hours field
    cur_hours = 5'd12;
    cur_minutes = 6'd34;
    cur_seconds = 6'd56;
    btn_mode = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    for (int k = 0; k < 160; k++) begin
      case (disp_sel)
        2'd0:    exp_val = (((k / 50) % 2) == 1) ? 0 : 12;
        2'd1:    exp_val = 34;
        2'd2:    exp_val = 56;
        default: exp_val = 255;
      endcase
      chk("blink", disp_data, exp_val);
      @(negedge clk);
    end
    btn_inc = 1'b1;
    @(negedge clk);
    btn_inc = 1'b0;
    for (int j = 0; j < 8; j++) begin
      case (disp_sel)
        2'd0:    exp_val = 13;
        2'd1:    exp_val = 34;
        2'd2:    exp_val = 56;
        default: exp_val = 255;
      endcase
      chk("blink_restore", disp_data, exp_val);
      @(negedge clk);
    end
    press_mode();
    press_mode();
    commit_check("blink_commit", 13, 34, 56);

    // Reset in SET_S
    cur_hours = 5'd1;
    cur_minutes = 6'd2;
    cur_seconds = 6'd3;
    press_mode();
    press_mode();
    press_mode();
    chk("sets_editing", editing, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_run", run, 0);
    chk("midrst_editing", editing, 0);
    chk("midrst_load", load, 0);
    chk("midrst_sel", disp_sel, 0);
    chk("midrst_data", disp_data, 0);
    chk("midrst_lh", load_hours, 0);
    chk("midrst_lm", load_minutes, 0);
    chk("midrst_ls", load_seconds, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_run", run, 1);
    chk("postrst_editing", editing, 0);
    chk("postrst_sel", disp_sel, 0);
    chk("postrst_data", disp_data, 1);
    #1;
    chk("postrst_load_count", load_cnt, 3);
    chk("final_no_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
